// File: rtl/nfc_pkg.sv
// nfc_pkg: shared state encoding and word width for the NAND flash scrambler.
package nfc_pkg;
  localparam int NFC_WORD_W = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, SEED = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;
endpackage

// File: rtl/nfc_out_reg.sv
// nfc_out_reg: one-entry valid/ready output register, no bubbles under continuous flow.
module nfc_out_reg
  import nfc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_load,
  input  logic [NFC_WORD_W-1:0] i_data,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [NFC_WORD_W-1:0] o_data
);
  logic                  r_valid;
  logic [NFC_WORD_W-1:0] r_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/nfc_rng_scrambler.sv
// nfc_rng_scrambler: seeds the randomizer per page and XORs each data word with its output.
module nfc_rng_scrambler
  import nfc_pkg::*;
#(
  parameter int LEN_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  bypass,
  input  logic [LEN_W-1:0]      word_len,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [NFC_WORD_W-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [NFC_WORD_W-1:0] m_data,
  output logic                  rng_en,
  output logic                  rng_rd,
  input  logic [NFC_WORD_W-1:0] rng_dat,
  output logic                  busy,
  output logic                  done
);
  state_t          r_state;
  logic [LEN_W-1:0] r_remain;
  logic            r_bypass;
  logic            r_rng_en;
  logic            r_done;
  logic            w_room;
  logic            w_acc;
  logic [NFC_WORD_W-1:0] w_data;
  assign w_room  = !m_valid | m_ready;
  assign s_ready = (r_state == RUN) & w_room & (r_remain != '0);
  assign w_acc   = s_valid & s_ready;
  assign rng_rd  = w_acc & !r_bypass;
  assign w_data  = s_data ^ (r_bypass ? '0 : rng_dat);
  assign busy    = r_state != IDLE;
  assign rng_en  = r_rng_en;
  assign done    = r_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_remain <= '0;
      r_bypass <= 1'b0;
      r_rng_en <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state  <= IDLE;
        r_remain <= '0;
        r_rng_en <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (start) begin
            if (word_len != '0) begin
              r_remain <= word_len;
              r_bypass <= bypass;
              r_rng_en <= 1'b1;
              r_state  <= SEED;
            end else begin
              r_done <= 1'b1;
            end
          end
          SEED: r_state <= RUN;
          RUN: if (w_acc) begin
            r_remain <= r_remain - LEN_W'(1);
            if (r_remain == LEN_W'(1)) r_state <= DRAIN;
          end
          DRAIN: if (w_room) begin
            r_done   <= 1'b1;
            r_rng_en <= 1'b0;
            r_state  <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
  nfc_out_reg u_out (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (abort),
    .i_load  (w_acc),
    .i_data  (w_data),
    .i_ready (m_ready),
    .o_valid (m_valid),
    .o_data  (m_data)
  );
endmodule

// File: tb/tb_nfc_rng_scrambler.sv
// tb_nfc_rng_scrambler: directed checks of the scrambler against a behavioural 32-bit LFSR generator.
module tb_nfc_rng_scrambler;
  logic        clk = 1'b0;
  logic        rst, start, abort, bypass, s_valid, m_ready;
  logic [11:0] word_len;
  logic [15:0] s_data;
  logic        s_ready, m_valid, rng_en, rng_rd, busy, done;
  logic [15:0] m_data, rng_dat;
  logic [31:0] seed, g;
  logic        en_q;
  logic [15:0] din [64];
  logic [15:0] q_out [$];
  int          n_rd, done_t, done_cnt, viol, en_seen;
  int          checks = 0, failures = 0;
  logic [31:0] w;

  always #5 clk = ~clk;

  nfc_rng_scrambler #(.LEN_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bypass(bypass),
    .word_len(word_len), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .rng_en(rng_en),
    .rng_rd(rng_rd), .rng_dat(rng_dat), .busy(busy), .done(done)
  );

  function automatic logic [31:0] adv16(input logic [31:0] x);
    logic [31:0] r = x;
    for (int k = 0; k < 16; k++) r = {r[30:0], r[31] ^ r[6] ^ r[4] ^ r[2] ^ r[1] ^ r[0]};
    return r;
  endfunction

  always @(posedge clk) begin
    en_q <= rng_en;
    if (rng_en && !en_q) g <= seed;
    else if (rng_rd) g <= adv16(g);
  end
  assign rng_dat = g[31:16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n, input logic byp, input bit rnd, input int abort_after, input int busy_start_t);
    int   idx = 0;
    logic acc;
    q_out.delete();
    n_rd = 0; done_t = -1; done_cnt = 0; viol = 0; en_seen = 0;
    for (int t = 0; t < 600; t++) begin
      start    = (t == 0) || (t == busy_start_t);
      word_len = (t == 0) ? 12'(n) : 12'd7;
      bypass   = (t == 0) ? byp : ~byp;
      abort    = (abort_after >= 0) && (idx == abort_after);
      s_valid  = (idx < n) && !abort && (t > 0);
      s_data   = din[idx % 64];
      m_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (m_valid && m_ready) q_out.push_back(m_data);
      if (rng_rd) n_rd++;
      if (rng_rd && m_valid && !m_ready) viol++;
      if (rng_en) en_seen = 1;
      if (done) begin done_cnt++; if (done_t < 0) done_t = t; end
      acc = s_valid & s_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      if (abort || (done_t >= 0 && t > done_t + 2)) break;
    end
    start = 0; abort = 0; s_valid = 0; m_ready = 1;
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; bypass = 0; s_valid = 1; m_ready = 1;
    word_len = 0; s_data = 16'h0; seed = 0; g = 0; en_q = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", {31'd0, m_valid}, 0);
    chk("rst_m_data", {16'd0, m_data}, 0);
    chk("rst_rng_en", {31'd0, rng_en}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_s_ready", {31'd0, s_ready}, 0);
    chk("rst_rng_rd", {31'd0, rng_rd}, 0);
    rst = 0; s_valid = 0;
    @(posedge clk); #1;

    seed = 32'h12345678;
    din[0] = 16'h0000; din[1] = 16'h0000;
    run(2, 1'b0, 1'b0, -1, -1);
    chk("p1_count", q_out.size(), 2);
    chk("p1_w0", {16'd0, q_out[0]}, 32'h1234);
    chk("p1_w1", {16'd0, q_out[1]}, 32'h5678);
    chk("p1_rd", n_rd, 2);
    chk("p1_done_t", done_t, 5);
    chk("p1_done_cnt", done_cnt, 1);

    for (int i = 0; i < 4; i++) din[i] = 16'hFFFF;
    run(4, 1'b0, 1'b0, -1, 3);
    w = adv16(adv16(seed));
    chk("p2_count", q_out.size(), 4);
    chk("p2_w0", {16'd0, q_out[0]}, 32'hEDCB);
    chk("p2_w1", {16'd0, q_out[1]}, 32'hA987);
    chk("p2_w2", {16'd0, q_out[2]}, {16'd0, ~w[31:16]});
    chk("p2_w3", {16'd0, q_out[3]}, {16'd0, ~adv16(w)[31:16]});
    chk("p2_done_t", done_t, 7);
    chk("p2_done_cnt", done_cnt, 1);

    din[0] = 16'hA5A5; din[1] = 16'h0001; din[2] = 16'hFFFF;
    run(3, 1'b1, 1'b0, -1, -1);
    chk("byp_count", q_out.size(), 3);
    chk("byp_w0", {16'd0, q_out[0]}, 32'hA5A5);
    chk("byp_w1", {16'd0, q_out[1]}, 32'h0001);
    chk("byp_w2", {16'd0, q_out[2]}, 32'hFFFF);
    chk("byp_rd", n_rd, 0);
    chk("byp_en_seen", en_seen, 1);
    chk("byp_done_t", done_t, 6);

    seed = 32'hACE12468;
    for (int i = 0; i < 64; i++) din[i] = 16'($urandom);
    run(64, 1'b0, 1'b1, -1, -1);
    chk("rnd_count", q_out.size(), 64);
    chk("rnd_rd", n_rd, 64);
    chk("rnd_viol", viol, 0);
    chk("rnd_done_cnt", done_cnt, 1);
    w = seed;
    for (int i = 0; i < 64 && i < q_out.size(); i++) begin
      chk($sformatf("rnd_w%0d", i), {16'd0, q_out[i]}, {16'd0, din[i] ^ w[31:16]});
      w = adv16(w);
    end

    seed = 32'h0BADF00D;
    run(10, 1'b0, 1'b0, 5, -1);
    chk("ab_busy", {31'd0, busy}, 0);
    chk("ab_m_valid", {31'd0, m_valid}, 0);
    chk("ab_rng_en", {31'd0, rng_en}, 0);
    chk("ab_rd", n_rd, 5);
    chk("ab_done_cnt", done_cnt, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("ab_no_done", {31'd0, done}, 0);
    seed = 32'hCAFEBABE;
    din[0] = 16'h1111;
    run(1, 1'b0, 1'b0, -1, -1);
    chk("ab_reseed_w0", {16'd0, q_out[0]}, 32'hDBEF);
    chk("ab_reseed_done_t", done_t, 4);

    run(0, 1'b0, 1'b0, -1, -1);
    chk("z_done_t", done_t, 1);
    chk("z_done_cnt", done_cnt, 1);
    chk("z_en_seen", en_seen, 0);
    chk("z_count", q_out.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
